// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-slot vending controller with per-slot price, stock, refund and change
module vending_machine_multi #(
    parameter int ITEMS    = 4,
    parameter int ITEM_W   = 2,
    parameter int CREDIT_W = 8,
    parameter int STOCK_W  = 4,
    parameter logic [ITEMS*CREDIT_W-1:0] PRICE_TABLE = {8'd4, 8'd3, 8'd2, 8'd1}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ITEM_W-1:0]   item_sel,
    input  logic                select,
    input  logic                five_in,
    input  logic                ten_in,
    input  logic                cancel,
    input  logic                restock,
    output logic                dispense,
    output logic [ITEM_W-1:0]   dispense_item,
    output logic                five_out,
    output logic                coin_reject,
    output logic                deny,
    output logic [CREDIT_W-1:0] credit,
    output logic [ITEMS-1:0]    sold_out,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE
    } state_t;

    localparam logic [STOCK_W-1:0] STOCK_FULL = '1;

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_r, credit_n;
    logic [STOCK_W-1:0]  stock [ITEMS];
    logic [ITEM_W-1:0]   item_r, item_n;
    logic                coin_reject_r, coin_reject_n;
    logic                deny_r, deny_n;
    logic                dec_en;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_sold;
    logic                coin_any;
    logic [CREDIT_W:0]   coin_sum;

    // A slot is unavailable when empty or disabled by a zero price
    for (genvar g = 0; g < ITEMS; g++) begin : g_sold
        assign sold_out[g] = (stock[g] == '0) || (PRICE_TABLE[g*CREDIT_W +: CREDIT_W] == '0);
    end

    // Look up price and availability of the requested slot; out-of-range indices read as sold out
    always_comb begin
        sel_price = '0;
        sel_sold  = 1'b1;
        for (int i = 0; i < ITEMS; i++) begin
            if (32'(item_sel) == i) begin
                sel_price = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
                sel_sold  = sold_out[i];
            end
        end
    end

    assign coin_any = five_in | ten_in;
    assign coin_sum = {1'b0, credit_r} + {{(CREDIT_W-1){1'b0}}, ten_in, five_in};

    // Next-state, credit and pulse decisions
    always_comb begin
        state_n       = state;
        credit_n      = credit_r;
        item_n        = '0;
        coin_reject_n = 1'b0;
        deny_n        = 1'b0;
        dec_en        = 1'b0;
        case (state)
            S_IDLE, S_COLLECT: begin
                if (cancel && state == S_COLLECT) begin
                    state_n       = S_CHANGE;
                    coin_reject_n = coin_any;
                end else if (select) begin
                    coin_reject_n = coin_any;
                    if (sel_sold || credit_r < sel_price) begin
                        deny_n = 1'b1;
                    end else begin
                        state_n  = S_VEND;
                        credit_n = credit_r - sel_price;
                        item_n   = item_sel;
                        dec_en   = 1'b1;
                    end
                end else if (coin_any) begin
                    if (coin_sum[CREDIT_W]) begin
                        coin_reject_n = 1'b1;
                    end else begin
                        credit_n = coin_sum[CREDIT_W-1:0];
                        state_n  = S_COLLECT;
                    end
                end
            end
            S_VEND: begin
                coin_reject_n = coin_any;
                state_n       = (credit_r != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_n = coin_any;
                if (credit_r <= CREDIT_W'(1)) begin
                    credit_n = '0;
                    state_n  = S_IDLE;
                end else begin
                    credit_n = credit_r - CREDIT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Control registers; reset forfeits any credit still being returned
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            credit_r      <= '0;
            item_r        <= '0;
            coin_reject_r <= 1'b0;
            deny_r        <= 1'b0;
        end else begin
            state         <= state_n;
            credit_r      <= credit_n;
            item_r        <= item_n;
            coin_reject_r <= coin_reject_n;
            deny_r        <= deny_n;
        end
    end

    // Stock counters; restock overrides a same-edge sale
    always_ff @(posedge clock or negedge reset) begin
        for (int i = 0; i < ITEMS; i++) begin
            if (!reset) begin
                stock[i] <= STOCK_FULL;
            end else if (restock) begin
                stock[i] <= STOCK_FULL;
            end else if (dec_en && 32'(item_sel) == i) begin
                stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

    assign dispense      = (state == S_VEND);
    assign five_out      = (state == S_CHANGE);
    assign busy          = (state == S_VEND) || (state == S_CHANGE);
    assign dispense_item = item_r;
    assign coin_reject   = coin_reject_r;
    assign deny          = deny_r;
    assign credit        = credit_r;

endmodule

// File: tb/tb_vending_machine_multi.sv
// tb/tb_vending_machine_multi.sv - scoreboard bench for vending_machine_multi
module tb_vending_machine_multi;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] item_sel = '0;
    logic       select = 1'b0, five_in = 1'b0, ten_in = 1'b0, cancel = 1'b0, restock = 1'b0;
    logic       dispense, five_out, coin_reject, deny, busy;
    logic [1:0] dispense_item;
    logic [7:0] credit;
    logic [3:0] sold_out;

    int errors = 0;
    int checks = 0;

    int m_credit;
    int m_stock [4];
    int price [4] = '{1, 2, 3, 4};

    int q_disp [$];
    int q_five [$];
    int q_deny [$];
    int q_rej  [$];

    vending_machine_multi dut (
        .clock(clock), .reset(reset), .item_sel(item_sel), .select(select),
        .five_in(five_in), .ten_in(ten_in), .cancel(cancel), .restock(restock),
        .dispense(dispense), .dispense_item(dispense_item), .five_out(five_out),
        .coin_reject(coin_reject), .deny(deny), .credit(credit),
        .sold_out(sold_out), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_sold();
        int v = 0;
        for (int i = 0; i < 4; i++)
            if (m_stock[i] == 0 || price[i] == 0) v |= (1 << i);
        return v;
    endfunction

    // Monitor: every output event must match the head of its expectation queue
    always @(negedge clock) begin
        if (reset) begin
            if (dispense) begin
                if (q_disp.size() == 0) chk("unexpected_dispense", 1, 0);
                else chk("dispense_item", int'(dispense_item), q_disp.pop_front());
            end else if (dispense_item != 2'd0) begin
                chk("dispense_item_idle", int'(dispense_item), 0);
            end
            if (five_out) begin
                if (q_five.size() == 0) chk("unexpected_five_out", 1, 0);
                else chk("credit_during_change", int'(credit), q_five.pop_front());
            end
            if (deny) begin
                if (q_deny.size() == 0) chk("unexpected_deny", 1, 0);
                else void'(q_deny.pop_front());
            end
            if (coin_reject) begin
                if (q_rej.size() == 0) chk("unexpected_coin_reject", 1, 0);
                else void'(q_rej.pop_front());
            end
        end
    end

    task automatic clear_inputs();
        five_in = 0; ten_in = 0; select = 0; cancel = 0; restock = 0; item_sel = '0;
    endtask

    // One sampling edge of stimulus: model predicts outcome, then wait for DUT to settle idle
    task automatic step(input bit f, input bit t, input bit s, input int it,
                        input bit c, input bit r, input bit bc);
        bit went_busy = 0;
        bit coin = f | t;
        int u = int'(f) + 2 * int'(t);
        int n = 0;
        if (c && m_credit > 0) begin
            if (coin) q_rej.push_back(1);
            for (int k = m_credit; k > 0; k--) q_five.push_back(k);
            m_credit = 0;
            went_busy = 1;
        end else if (s) begin
            if (coin) q_rej.push_back(1);
            if (m_stock[it] == 0 || price[it] == 0 || m_credit < price[it]) begin
                q_deny.push_back(1);
            end else begin
                q_disp.push_back(it);
                m_credit -= price[it];
                m_stock[it]--;
                for (int k = m_credit; k > 0; k--) q_five.push_back(k);
                m_credit = 0;
                went_busy = 1;
            end
        end else if (coin) begin
            if (m_credit + u > 255) q_rej.push_back(1);
            else m_credit += u;
        end
        if (r) for (int i = 0; i < 4; i++) m_stock[i] = 15;

        five_in = f; ten_in = t; select = s; item_sel = 2'(it); cancel = c; restock = r;
        @(posedge clock); #1;
        clear_inputs();
        if (bc && went_busy) begin
            five_in = 1; ten_in = 1'($urandom_range(0, 1)); select = 1; cancel = 1;
            item_sel = 2'($urandom_range(0, 3));
            q_rej.push_back(1);
            @(posedge clock); #1;
            clear_inputs();
        end
        while (busy && n < 600) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 600) chk("busy_timeout", 1, 0);
        @(negedge clock); #1;
        chk("credit", int'(credit), m_credit);
        chk("sold_out", int'(sold_out), exp_sold());
    endtask

    initial begin
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 15;
        clear_inputs();
        reset = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_dispense", int'(dispense), 0);
        chk("rst_five_out", int'(five_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_deny", int'(deny), 0);
        chk("rst_coin_reject", int'(coin_reject), 0);
        chk("rst_dispense_item", int'(dispense_item), 0);
        chk("rst_sold_out", int'(sold_out), 0);
        reset = 1;

        // five, ten, buy slot 2 at exact credit
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0, 0);
        // ten, ten, buy slot 0 -> three fives
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        // insufficient credit then cancel
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        // coin with select, coin during busy
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 1);

        // overflow boundary at 254/255
        for (int i = 0; i < 127; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int op = $urandom_range(0, 9);
            int it = $urandom_range(0, 3);
            bit f = 1'($urandom_range(0, 1));
            bit t = 1'($urandom_range(0, 1));
            bit bc = ($urandom_range(0, 2) == 0);
            case (op)
                0, 1, 2, 3: step(f, t | ~f, 0, it, 0, 0, 0);
                4, 5, 6:    step(0, 0, 1, it, 0, 0, bc);
                7:          step(f, 0, 0, it, 1, 0, bc);
                8:          step(f, t, 1, it, 0, 0, bc);
                default:    step(0, 0, ($urandom_range(0, 1) == 1), it, 0, 1, 0);
            endcase
        end

        // reset asserted mid-change with credit 3
        step(1, 1, 0, 0, 0, 0, 0);
        for (int k = m_credit; k > 0; k--) q_five.push_back(k);
        cancel = 1;
        @(posedge clock); #1;
        cancel = 0;
        @(negedge clock); #1;
        reset = 0;
        #1;
        chk("midrst_five_out", int'(five_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_credit", int'(credit), 0);
        chk("midrst_sold_out", int'(sold_out), 0);
        q_five.delete();
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 15;
        @(posedge clock); #1;
        reset = 1;

        // deplete slot 0, then denial, then restock
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            step(0, 0, 1, 0, 0, 0, 0);
        end
        chk("slot0_sold_out", int'(sold_out[0]), 1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("slot0_restocked", int'(sold_out[0]), 0);
        step(0, 0, 0, 0, 1, 0, 0);

        repeat (3) @(posedge clock);
        #1;
        chk("pending_dispense", q_disp.size(), 0);
        chk("pending_five_out", q_five.size(), 0);
        chk("pending_deny", q_deny.size(), 0);
        chk("pending_coin_reject", q_rej.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised successor to the single-item vending controller: multi-slot item selection with a per-slot price table, per-slot stock counters with sold-out flags, cancel/refund, coin rejection, and change returned as a train of five-unit pulses. It sits between the coin acceptor and dispenser mechanics. All money is counted in units of 5: five = 1 unit, ten = 2 units.

## Interface
- ITEMS, 4, number of item slots
- ITEM_W, 2, width of item select, ≥ clog2(ITEMS)
- CREDIT_W, 8, width of credit register in units; max credit 2^CREDIT_W−1
- STOCK_W, 4, width of each slot's stock counter; full = 2^STOCK_W−1
- PRICE_TABLE, {8'd4,8'd3,8'd2,8'd1}, ITEMS×CREDIT_W flattened prices in units; slot i at bits [i*CREDIT_W +: CREDIT_W]; price 0 = slot disabled

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- item_sel  in  ITEM_W  slot index for select
- select  in  1  one-cycle purchase request for item_sel
- five_in  in  1  five coin inserted (one-cycle pulse)
- ten_in  in  1  ten coin inserted (one-cycle pulse)
- cancel  in  1  refund request
- restock  in  1  set all stock counters to full
- dispense  out  1  one-cycle vend pulse
- dispense_item  out  ITEM_W  slot being vended; valid while dispense=1, else 0
- five_out  out  1  one five returned per cycle asserted
- coin_reject  out  1  one-cycle pulse: coin(s) sampled this edge not credited
- deny  out  1  one-cycle pulse: select refused
- credit  out  CREDIT_W  current credit in units
- sold_out  out  ITEMS  bit i = stock[i]==0 or price[i]==0
- busy  out  1  high in VEND or CHANGE

## Operation
- States: IDLE (credit=0), COLLECT (credit>0), VEND, CHANGE. dispense=(state==VEND), five_out=(state==CHANGE), busy=VEND|CHANGE, all decoded from registers.
- Coins in IDLE/COLLECT: add 1 (five), 2 (ten), 3 (both). If sum exceeds 2^CREDIT_W−1, whole sample rejected: credit unchanged, coin_reject=1. Any coin in VEND/CHANGE: coin_reject=1, not credited.
- select in IDLE/COLLECT, no cancel: if sold_out[item_sel] or credit<price[item_sel] → deny=1, state unchanged. Else → VEND: credit −= price, stock[item_sel] −= 1, dispense_item latched. item_sel ≥ ITEMS → deny.
- select with coin same edge: select evaluated on pre-edge credit; coin rejected (coin_reject=1).
- cancel in COLLECT → CHANGE, credit retained for return; cancel wins over select and coins (coins rejected). cancel in IDLE/VEND/CHANGE ignored.
- VEND lasts one cycle → CHANGE if credit>0, else IDLE.
- CHANGE: each edge credit −= 1; on edge where credit==1 → IDLE. Number of five_out cycles = credit on entry.
- select/cancel during VEND/CHANGE ignored (no deny).
- restock: any state, all stock counters = full; overrides a same-edge decrement.
- Stock never wraps: decrement only occurs when stock>0 (guaranteed by sold_out check).

## Timing
- Reset (asynchronous, active low): state IDLE, credit 0, all stock counters full; dispense, dispense_item, five_out, coin_reject, deny, busy = 0; sold_out = bits of slots with price 0. Reset mid-CHANGE forfeits unreturned credit.
- All inputs sampled on rising clock; every output changes only on rising clock or reset.
- Coin credit visible on credit the cycle after sampling edge.
- Accepted select at edge k: dispense high cycle k..k+1, credit already reduced; first five_out cycle immediately follows dispense.
- cancel at edge k: five_out high for exactly credit consecutive cycles starting after edge k.
- coin_reject and deny: single cycle after the offending sampling edge.
- Best-case purchase-to-idle latency: 1 + change cycles.

## Test plan
- Reset, five, ten, select slot 2 (price 3) → credit 1,3; dispense 1 cycle with dispense_item=2, credit 0, back to IDLE, no five_out.
- Ten, ten, select slot 0 (price 1) → dispense, then five_out exactly 3 consecutive cycles, credit 3,2,1,0, then IDLE.
- Five, select slot 3 (price 4) → deny 1 cycle, credit stays 1; cancel → five_out 1 cycle, credit 0.
- Vend slot 0 fifteen times (STOCK_W=4) → sold_out[0]=1, next select 0 denied; restock → sold_out[0]=0.
- Coin during CHANGE and coin+select same cycle → coin_reject, credit unaffected; ten at credit 254 → coin_reject, credit 254.
- Assert reset low mid-CHANGE with credit 3 → five_out, busy, credit 0 immediately; stock full.
